// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level to press/long/repeat/release pulses
// Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic press,
  output logic long_press,
  output logic rpt,
  output logic release_p,
  output logic short_click,
  output logic held
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             clean_q;
  logic             press_d, long_d, rpt_d, release_d, short_d;

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (clean && !clean_q) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_PRESSED: begin
        // Release takes priority over a long-press due on the same edge.
        if (!clean) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
          cnt_d     = '0;
        end else if (cnt_inc == LONG_C) begin
          state_d = S_LONG;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LONG: begin
        if (!clean) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_inc == CNT_W'(REPEAT_CYCLES)) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // clean_q resets to 1 so a button held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      clean_q     <= 1'b1;
      press       <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      release_p   <= 1'b0;
      short_click <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      clean_q     <= clean;
      press       <= press_d;
      long_press  <= long_d;
      rpt         <= rpt_d;
      release_p   <= release_d;
      short_click <= short_d;
      held        <= (state_d != S_IDLE);
    end
  end

endmodule
